// File: rtl/int2fp_pkg.sv
// int2fp_pkg: shared types, constants and round-robin picker for the int32->fp32 arbiter.
package int2fp_pkg;
  localparam int FP32_BIAS = 127;
  localparam int MAXREQ = 8;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  // One-hot grant for the first valid bit at or after ptr, wrapping within n lanes.
  function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] valid, input logic [2:0] ptr, input int n);
    logic [MAXREQ-1:0] g;
    logic found;
    int idx;
    g = '0;
    found = 1'b0;
    for (int i = 0; i < MAXREQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && valid[idx]) begin
        g[idx] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction
endpackage

// File: rtl/int2fp32_core.sv
// int2fp32_core: combinational int32/uint32 to fp32 converter, round-to-nearest-even.
module int2fp32_core
  import int2fp_pkg::*;
(
  input  logic [31:0] in,
  input  logic        is_signed,
  output logic [31:0] out
);
  logic        sgn;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  lzc;
  logic        rnd;
  logic [23:0] man_r;
  logic [8:0]  e;
  fp32_t       r;

  always_comb begin
    sgn = is_signed && in[31];
    mag = sgn ? -in : in;
    lzc = '0;
    for (int i = 0; i < 32; i++) if (mag[i]) lzc = 5'(31 - i);
    norm = mag << lzc;
    // guard is norm[7]; ties resolve toward the even mantissa lsb norm[8]
    rnd = norm[7] && (norm[8] || |norm[6:0]);
    man_r = {1'b0, norm[30:8]} + 24'(rnd);
    e = 9'(FP32_BIAS + 31) - 9'(lzc) + 9'(man_r[23]);
    r.sign = sgn;
    r.exp = e[7:0];
    r.man = man_r[23] ? '0 : man_r[22:0];
    out = (mag == '0) ? '0 : r;
  end
endmodule

// File: rtl/int2fp_arb.sv
// int2fp_arb: round-robin arbiter feeding a shared 2-stage int32->fp32 pipeline
// with full back-pressure; results are tagged with the requester index.
module int2fp_arb
  import int2fp_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_data,
  input  logic [NREQ-1:0]   req_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [IDW-1:0]    out_id,
  output logic              busy
);
  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_op_q, s1_op_d;
  logic            s1_sgn_q, s1_sgn_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            s1_ready, s2_ready, take, sgn_sel;
  logic [MAXREQ-1:0] pick;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gid;
  logic [31:0]     op_sel, conv;

  int2fp32_core u_core (
    .in        (s1_op_q),
    .is_signed (s1_sgn_q),
    .out       (conv)
  );

  always_comb begin
    s2_ready = !out_valid_q || out_ready;
    s1_ready = !s1_valid_q || s2_ready;
    pick = rr_pick(MAXREQ'(req_valid), 3'(rr_ptr_q), NREQ);
    // gated by rst_n so grants vanish the moment reset asserts
    grant = (s1_ready && rst_n) ? pick[NREQ-1:0] : '0;
    gid = '0;
    op_sel = '0;
    sgn_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gid = IDW'(i);
        op_sel = req_data[32*i +: 32];
        sgn_sel = req_signed[i];
      end
    end
    take = |grant;
    s1_valid_d = s1_ready ? take : s1_valid_q;
    s1_op_d = take ? op_sel : s1_op_q;
    s1_sgn_d = take ? sgn_sel : s1_sgn_q;
    s1_id_d = take ? gid : s1_id_q;
    out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
    out_data_d = (s2_ready && s1_valid_q) ? conv : out_data_q;
    out_id_d = (s2_ready && s1_valid_q) ? s1_id_q : out_id_q;
    rr_ptr_d = take ? ((gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1) : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q <= '0;
      s1_sgn_q <= 1'b0;
      s1_id_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q <= s1_op_d;
      s1_sgn_q <= s1_sgn_d;
      s1_id_q <= s1_id_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_id_q <= out_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign req_ready = grant;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_id = out_id_q;
  assign busy = s1_valid_q || out_valid_q;
endmodule
